// File: rtl/fft8_ctrl.sv
// fft8_ctrl: valid/ready sequencer that drives the butterfly load enables
// of a 3-stage 8-point FFT datapath and counts delivered frames.
module fft8_ctrl #(
  parameter bit PIPELINED = 1'b1,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  output logic              en_bf1_1,
  output logic              en_bf1_2,
  output logic              en_bf1_3,
  output logic              en_bf1_4,
  output logic              en_bf2_1,
  output logic              en_bf2_2,
  output logic              en_bf3,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);
  logic              r_v1, r_v2, r_v3;
  logic [FCNT_W-1:0] r_cnt;
  logic              w_e1, w_e2, w_e3, w_rdy, w_fire;
  // Enables resolve from the output end backwards so a full pipe shifts in one cycle.
  always_comb begin
    w_fire = r_v3 & out_ready;
    w_e3   = ~flush & r_v2 & (~r_v3 | out_ready);
    w_e2   = ~flush & r_v1 & (~r_v2 | w_e3);
    w_rdy  = reset_n & ~flush & (PIPELINED ? (~r_v1 | w_e2) : ~(r_v1 | r_v2 | r_v3));
    w_e1   = in_valid & w_rdy;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + FCNT_W'(w_fire);
      r_v1  <= ~flush & (w_e1 | (r_v1 & ~w_e2));
      r_v2  <= ~flush & (w_e2 | (r_v2 & ~w_e3));
      r_v3  <= ~flush & (w_e3 | (r_v3 & ~out_ready));
    end
  end
  assign in_ready  = w_rdy;
  assign out_valid = r_v3;
  assign busy      = r_v1 | r_v2 | r_v3;
  assign en_bf1_1  = w_e1;
  assign en_bf1_2  = w_e1;
  assign en_bf1_3  = w_e1;
  assign en_bf1_4  = w_e1;
  assign en_bf2_1  = w_e2;
  assign en_bf2_2  = w_e2;
  assign en_bf3    = w_e3;
  assign frame_cnt = r_cnt;
endmodule

// File: tb/tb_fft8_ctrl.sv
// tb_fft8_ctrl: checks a pipelined (16-bit count) and a single-frame (3-bit count)
// controller against a frame-occupancy model, tracking frame ids through bench-side stage registers.
module tb_fft8_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [1:0] in_ready, out_valid, busy, e11, e12, e13, e14, e21, e22, e3;
  logic [15:0] fc1;
  logic [2:0]  fc0;
  int st[2][3];
  int dp[2][3];
  int mcnt[2];
  int nid[2];
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  fft8_ctrl #(.PIPELINED(1'b1), .FCNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .flush(flush),
    .en_bf1_1(e11[1]), .en_bf1_2(e12[1]), .en_bf1_3(e13[1]), .en_bf1_4(e14[1]),
    .en_bf2_1(e21[1]), .en_bf2_2(e22[1]), .en_bf3(e3[1]), .busy(busy[1]), .frame_cnt(fc1));

  fft8_ctrl #(.PIPELINED(1'b0), .FCNT_W(3)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .flush(flush),
    .en_bf1_1(e11[0]), .en_bf1_2(e12[0]), .en_bf1_3(e13[0]), .en_bf1_4(e14[0]),
    .en_bf2_1(e21[0]), .en_bf2_2(e22[0]), .en_bf3(e3[0]), .busy(busy[0]), .frame_cnt(fc0));

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int k);
    return k == 1 ? 32'(fc1) : 32'(fc0);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      for (int s = 0; s < 3; s++) st[k][s] = -1;
    end
  endtask

  // One clock: drive inputs mid-cycle, compare against the occupancy model, advance the model.
  task automatic cyc(input bit iv, input bit ordy, input bit fl);
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit fire, m1, m2, m3, rdy, empty;
      empty = st[k][0] < 0 && st[k][1] < 0 && st[k][2] < 0;
      fire  = st[k][2] >= 0 && ordy;
      m3    = !fl && st[k][1] >= 0 && (st[k][2] < 0 || fire);
      m2    = !fl && st[k][0] >= 0 && (st[k][1] < 0 || m3);
      rdy   = !fl && (k == 1 ? (st[k][0] < 0 || m2) : empty);
      m1    = iv && rdy;
      chk("in_ready", k, 32'(in_ready[k]), 32'(rdy));
      chk("en_bf1", k, 32'({e11[k], e12[k], e13[k], e14[k]}), 32'({4{m1}}));
      chk("en_bf2", k, 32'({e21[k], e22[k]}), 32'({2{m2}}));
      chk("en_bf3", k, 32'(e3[k]), 32'(m3));
      chk("out_valid", k, 32'(out_valid[k]), 32'(st[k][2] >= 0));
      chk("busy", k, 32'(busy[k]), 32'(!empty));
      chk("frame_cnt", k, cnt_of(k), 32'(mcnt[k]));
      if (fire) begin
        chk("frame_id", k, 32'(dp[k][2]), 32'(st[k][2]));
        mcnt[k] = (mcnt[k] + 1) & (k == 1 ? 32'hFFFF : 32'h7);
      end
      if (e3[k]) dp[k][2] = dp[k][1];
      if (e21[k]) dp[k][1] = dp[k][0];
      if (e11[k]) dp[k][0] = nid[k];
      if (fl) begin
        for (int s = 0; s < 3; s++) st[k][s] = -1;
      end else begin
        st[k][2] = m3 ? st[k][1] : (fire ? -1 : st[k][2]);
        st[k][1] = m2 ? st[k][0] : (m3 ? -1 : st[k][1]);
        st[k][0] = m1 ? nid[k] : (m2 ? -1 : st[k][0]);
      end
      if (m1) nid[k]++;
    end
    @(posedge clk);
  endtask

  task automatic rst_hold(input int n);
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    model_clear();
    repeat (n) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        chk("rst_en", k, 32'({e11[k], e12[k], e13[k], e14[k], e21[k], e22[k], e3[k]}), 32'd0);
        chk("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
        chk("rst_busy", k, 32'(busy[k]), 32'd0);
        chk("rst_cnt", k, cnt_of(k), 32'd0);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      nid[k] = 0;
      for (int s = 0; s < 3; s++) dp[k][s] = -2;
    end
    model_clear();
    rst_hold(2);
    cyc(1, 1, 0);
    repeat (4) cyc(0, 1, 0);
    chk("single_cnt", 1, cnt_of(1), 32'd1);
    repeat (4) cyc(1, 1, 0);
    repeat (4) cyc(0, 1, 0);
    chk("b2b_cnt", 1, cnt_of(1), 32'd5);
    chk("b2b_idle", 1, 32'(busy[1]), 32'd0);
    repeat (6) cyc(1, 0, 0);
    chk("bp_full", 1, 32'(in_ready[1]), 32'd0);
    cyc(1, 1, 0);
    repeat (5) cyc(0, 1, 0);
    repeat (12) cyc(1, 1, 0);
    cyc(0, 1, 1);
    repeat (4) cyc(0, 1, 0);
    chk("flush_idle", 1, 32'(busy[1]), 32'd0);
    repeat (4) cyc(1, 0, 0);
    rst_hold(1);
    chk("rst_mid_cnt", 1, cnt_of(1), 32'd0);
    repeat (500) cyc($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(39) == 0);
    repeat (6) cyc(0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fft8_ctrl.md
Name: fft8_ctrl

Overview:
- Sequencing controller for the 3-stage 8-point FFT datapath (stage 1: four radix-2 butterflies, stage 2: two, stage 3: one; each stage registered, loaded only when its enable is high).
- Drives the seven butterfly enables (en_bf1_1..4, en_bf2_1..2, en_bf3) from a valid/ready frame handshake. Frames advance stage by stage and the datapath stalls correctly under output backpressure.
- Sits between the sample source (eight parallel x0..x7 samples = one frame) and the consumer of the X_k_re/X_k_im outputs.

Parameters:
PIPELINED, 1, 1 = up to 3 frames in flight (one per stage); 0 = single frame in flight
FCNT_W, 16, width of completed-frame counter

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  source presents a frame on x0..x7
in_ready  out  1  controller accepts frame this cycle (transfer = in_valid & in_ready)
out_valid  out  1  datapath X outputs hold a valid frame
out_ready  in  1  consumer accepts frame this cycle (transfer = out_valid & out_ready)
flush  in  1  synchronous discard of all in-flight frames
en_bf1_1, en_bf1_2, en_bf1_3, en_bf1_4  out  1 each  stage-1 butterfly register load enables (identical value)
en_bf2_1, en_bf2_2  out  1 each  stage-2 register load enables (identical value)
en_bf3  out  1  stage-3 register load enable
busy  out  1  any stage holds a valid frame
frame_cnt  out  FCNT_W  frames delivered (out_valid & out_ready), wraps modulo 2^FCNT_W

Behaviour:
- State: three valid flags v1, v2, v3 (stage 1/2/3 registers hold valid data); out_valid = v3; busy = v1|v2|v3.
- Reset (async, reset_n=0): v1=v2=v3=0, frame_cnt=0. Hence out_valid=0, busy=0. All enables are 0 while reset_n=0. Reset mid-operation silently drops in-flight frames; no partial output is produced.
- Enables (combinational, same cycle as the data move):
  - e3 = v2 & (~v3 | out_ready)
  - e2 = v1 & (~v2 | e3)
  - PIPELINED=1: e1 = in_valid & (~v1 | e2); in_ready = ~v1 | e2
  - PIPELINED=0: in_ready = ~(v1|v2|v3); e1 = in_valid & in_ready
  - en_bf1_* = e1, en_bf2_* = e2, en_bf3 = e3
  - flush=1 forces e1=e2=e3=0 and in_ready=0.
- Flag update (non-flush): v1 <= e1 | (v1 & ~e2); v2 <= e2 | (v2 & ~e3); v3 <= e3 | (v3 & ~out_ready).
- flush=1: v1=v2=v3=0 next cycle. frame_cnt still counts a transfer occurring in that same cycle (out_valid & out_ready sampled before the clear).
- Latency: frame accepted in cycle t gives out_valid=1 from cycle t+3 when no stall. Throughput with PIPELINED=1 and out_ready held 1 is one frame per cycle. PIPELINED=0 accepts at most one frame per 4 cycles.
- Enables are asserted only when valid data moves. A stage register is never loaded with a bubble, so a stalled frame's X outputs stay stable while out_valid=1 & out_ready=0.
- Full pipeline (v1=v2=v3=1) with out_ready=0: all enables 0, in_ready=0. When out_ready rises, all three stages shift in the same cycle and in_ready=1 in that cycle.
- in_ready has a combinational path from out_ready. Consumer must not make out_ready depend on in_ready.
- in_valid may drop without a transfer. Sample values are not the controller's concern.
- frame_cnt: +1 per out_valid & out_ready. Wraps from 2^FCNT_W-1 to 0.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> all enables 0, out_valid=0, busy=0, frame_cnt=0. Release at mid-cycle -> first acceptance on the next rising edge.
- Single frame, PIPELINED=1, out_ready=1, in_valid pulsed in cycle 0 -> en_bf1_*=1 in cycle 0, en_bf2_*=1 in cycle 1, en_bf3=1 in cycle 2, out_valid=1 in cycle 3 only, frame_cnt=1. With x={501,604,230,-1015,2324,-304,-530,1715}, X_0_re=3525 and X_0_im=0.
- Back-to-back: 4 frames in cycles 0-3, out_ready=1 -> in_ready stays 1, out_valid=1 in cycles 3-6, frame_cnt=4, busy=0 in cycle 7.
- Backpressure: out_ready=0, in_valid=1 continuously -> 3 frames accepted (cycles 0-2), in_ready=0 from cycle 3, all enables 0, X outputs constant. out_ready=1 in cycle 6 -> en_bf1/2/3 all 1 and in_ready=1 in cycle 6.
- PIPELINED=0: in_valid held 1, out_ready=1 -> acceptances in cycles 0, 4, 8. out_valid in cycles 3, 7, 11.
- Flush with v1=v2=1, v3=1, out_ready=1 -> frame_cnt +1 that cycle, all valids 0 next cycle, no further out_valid. Second test: reset_n pulsed low mid-operation -> same clear, frame_cnt=0.
